// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - command handshake between the program sequencer and the AHB master
interface instr_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [2:0] cmd_burst;
  logic       cmd_sel;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_done;
  logic [7:0] rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_wdata,
    input  cmd_ready, cmd_done, rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_burst, cmd_sel, cmd_addr, cmd_wdata,
    output cmd_ready, cmd_done, rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/issue/wait sequencer feeding one decoded command per instruction to the AHB master
// Optional WAIT-state timeout abort is enabled with SEQ_TIMEOUT_EN.
module instr_sequencer #(
  parameter int PROG_LEN = 36,
  parameter int TIMEOUT  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [9:0]        o_pc,
  input  logic [22:0]       i_instruction,
  instr_sequencer_if.master cmd,
  output logic [7:0]        o_last_rdata,
  output logic [9:0]        o_rd_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

  localparam logic [9:0] LAST_PC = 10'(PROG_LEN - 1);

  if ((PROG_LEN < 1) || (PROG_LEN > 1024) || (TIMEOUT < 1)) begin : g_bad_cfg
    $error("instr_sequencer: parameter out of range");
  end

  state_t     r_state, w_next_state;
  logic [9:0] r_pc, r_rd_count, r_cmd_addr;
  logic [7:0] r_cmd_wdata, r_last_rdata;
  logic [2:0] r_cmd_burst;
  logic       r_cmd_write, r_cmd_sel;
  logic       w_start_run, w_last_instr, w_timeout;

  assign w_start_run  = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
  assign w_last_instr = (r_pc == LAST_PC);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_next_state = S_FETCH;
      S_FETCH:        w_next_state = S_ISSUE;
      S_ISSUE:        if (cmd.cmd_ready) w_next_state = S_WAIT;
      S_WAIT: begin
        if (cmd.cmd_done)   w_next_state = S_NEXT;
        else if (w_timeout) w_next_state = S_DONE;
      end
      S_NEXT:         w_next_state = w_last_instr ? S_DONE : S_FETCH;
      default:        w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc         <= '0;
      r_rd_count   <= '0;
      r_last_rdata <= '0;
      r_cmd_write  <= 1'b0;
      r_cmd_burst  <= '0;
      r_cmd_sel    <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
    end else begin
      if (w_start_run) begin
        r_pc       <= '0;
        r_rd_count <= '0;
      end
      if (r_state == S_FETCH) begin
        r_cmd_write <= i_instruction[22];
        r_cmd_burst <= i_instruction[21:19];
        r_cmd_sel   <= i_instruction[18];
        r_cmd_addr  <= i_instruction[17:8];
        r_cmd_wdata <= i_instruction[7:0];
      end
      if ((r_state == S_WAIT) && cmd.cmd_done && !r_cmd_write) begin
        r_last_rdata <= cmd.rdata;
        r_rd_count   <= r_rd_count + 10'd1;
      end
      // pc stops on the last instruction so it never wraps past PROG_LEN-1
      if ((r_state == S_NEXT) && !w_last_instr) r_pc <= r_pc + 10'd1;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_error;

  // counts completed WAIT cycles; the TIMEOUT-th one without cmd_done aborts
  assign w_timeout = (r_wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
      r_error    <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_start_run)
        r_error <= 1'b0;
      else if ((r_state == S_WAIT) && !cmd.cmd_done && w_timeout)
        r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`else
  assign w_timeout = 1'b0;
  assign o_error   = 1'b0;
`endif

  assign cmd.cmd_valid = (r_state == S_ISSUE);
  assign cmd.cmd_write = r_cmd_write;
  assign cmd.cmd_burst = r_cmd_burst;
  assign cmd.cmd_sel   = r_cmd_sel;
  assign cmd.cmd_addr  = r_cmd_addr;
  assign cmd.cmd_wdata = r_cmd_wdata;

  assign o_pc         = r_pc;
  assign o_last_rdata = r_last_rdata;
  assign o_rd_count   = r_rd_count;
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done       = (r_state == S_DONE);
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed bench for instr_sequencer with a small master and slave memory model
module tb_instr_sequencer;
  localparam logic [22:0] ONE_INSTR = 23'b1_000_0_0000000001_00000001;

  logic        clk, rst, start, start1;
  logic [9:0]  pc, pc1, rd_count, rd_count1;
  logic [7:0]  last_rdata, last_rdata1;
  logic        busy, busy1, done, done1, error, error1;
  logic [22:0] instr;
  logic [22:0] prog [0:1023];
  logic [7:0]  smem [0:1][0:1023];
  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;
  int          hs0;
  bit          ok;

  instr_sequencer_if u_if ();
  instr_sequencer_if u_if1 ();

  assign instr = prog[pc];

  instr_sequencer #(.PROG_LEN(36), .TIMEOUT(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_pc(pc), .i_instruction(instr),
    .cmd(u_if), .o_last_rdata(last_rdata), .o_rd_count(rd_count),
    .o_busy(busy), .o_done(done), .o_error(error)
  );

  instr_sequencer #(.PROG_LEN(1)) u_one (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_pc(pc1), .i_instruction(ONE_INSTR),
    .cmd(u_if1), .o_last_rdata(last_rdata1), .o_rd_count(rd_count1),
    .o_busy(busy1), .o_done(done1), .o_error(error1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (u_if.cmd_valid && u_if.cmd_ready) hs_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output bit seen);
    int n;
    n = 0;
    while (u_if.cmd_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    seen = (u_if.cmd_valid === 1'b1);
    chk("valid_seen", 32'(seen), 1);
  endtask

  task automatic serve(input int idx, input int rdly, input int ddly);
    logic [22:0] f;
    bit seen;
    wait_valid(seen);
    if (!seen) return;
    f = {u_if.cmd_write, u_if.cmd_burst, u_if.cmd_sel, u_if.cmd_addr, u_if.cmd_wdata};
    chk("issue_pc", 32'(pc), 32'(idx));
    chk("cmd_fields", 32'(f), 32'(prog[idx]));
    for (int k = 0; k < rdly; k++) begin
      u_if.cmd_ready = 1'b0;
      tick();
      chk("bp_valid", 32'(u_if.cmd_valid), 1);
      chk("bp_stable", 32'({u_if.cmd_addr, u_if.cmd_wdata}), 32'(f[17:0]));
    end
    u_if.cmd_ready = 1'b1;
    tick();
    u_if.cmd_ready = 1'b0;
    chk("valid_drop", 32'(u_if.cmd_valid), 0);
    if (f[22]) smem[f[18]][f[17:8]] = f[7:0];
    for (int k = 1; k < ddly; k++) tick();
    u_if.rdata    = smem[f[18]][f[17:8]];
    u_if.cmd_done = 1'b1;
    tick();
    u_if.cmd_done = 1'b0;
    u_if.rdata    = 8'h00;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      prog[a]    = '0;
      smem[0][a] = '0;
      smem[1][a] = '0;
    end
    // pair p: write then read back slave p%2, addr p/2+1, data p/2+3
    for (int p = 0; p < 18; p++) begin
      prog[2*p]   = {1'b1, 3'(p % 8), 1'(p % 2), 10'(p / 2 + 1), 8'(p / 2 + 3)};
      prog[2*p+1] = {1'b0, 3'(p % 8), 1'(p % 2), 10'(p / 2 + 1), 8'h00};
    end

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    u_if.cmd_ready = 1'b0;  u_if.cmd_done = 1'b0;  u_if.rdata = 8'h00;
    u_if1.cmd_ready = 1'b0; u_if1.cmd_done = 1'b0; u_if1.rdata = 8'h00;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(u_if.cmd_valid), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    chk("rst_last_rdata", 32'(last_rdata), 0);
    chk("rst_cmd", 32'({u_if.cmd_write, u_if.cmd_burst, u_if.cmd_sel, u_if.cmd_addr, u_if.cmd_wdata}), 0);
    repeat (5) tick();
    chk("idle_hold_busy", 32'(busy), 0);
    chk("idle_hold_valid", 32'(u_if.cmd_valid), 0);
    chk("idle_hold_done", 32'(done), 0);

    // single write, PROG_LEN=1, done sampled 2 cycles after accept
    u_if1.cmd_ready = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("one_fetch_busy", 32'(busy1), 1);
    chk("one_fetch_valid", 32'(u_if1.cmd_valid), 0);
    tick();
    chk("one_issue_valid", 32'(u_if1.cmd_valid), 1);
    chk("one_fields", 32'({u_if1.cmd_write, u_if1.cmd_sel, u_if1.cmd_addr, u_if1.cmd_wdata}),
        32'({1'b1, 1'b0, 10'd1, 8'd1}));
    tick();
    chk("one_valid_drop", 32'(u_if1.cmd_valid), 0);
    tick();
    u_if1.cmd_done = 1'b1; u_if1.rdata = 8'hEE;
    tick();
    u_if1.cmd_done = 1'b0; u_if1.rdata = 8'h00;
    chk("one_next_done", 32'(done1), 0);
    tick();
    chk("one_done_5cyc", 32'(done1), 1);
    chk("one_busy_end", 32'(busy1), 0);
    chk("one_rd_count", 32'(rd_count1), 0);
    chk("one_pc", 32'(pc1), 0);
    chk("one_last_rdata", 32'(last_rdata1), 0);

    // full 36-instruction program with backpressure and a start pulse while busy
    hs0 = hs_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy", 32'(busy), 1);
    for (int i = 0; i < 36; i++) begin
      if (i == 5) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      serve(i, (i == 0) ? 7 : i % 3, 1 + i % 3);
      if (i % 2 == 1) begin
        chk("rd_count_run", 32'(rd_count), 32'((i + 1) / 2));
        chk("last_rdata_run", 32'(last_rdata), 32'((i / 2) / 2 + 3));
      end
    end
    for (int n = 0; n < 10 && done !== 1'b1; n++) tick();
    chk("full_done", 32'(done), 1);
    chk("full_busy", 32'(busy), 0);
    chk("full_pc", 32'(pc), 35);
    chk("full_rd_count", 32'(rd_count), 18);
    chk("full_last_rdata", 32'(last_rdata), 32'h0B);
    chk("full_handshakes", 32'(hs_cnt - hs0), 36);
    chk("full_error", 32'(error), 0);
    u_if.cmd_done = 1'b1; u_if.rdata = 8'hFF;
    tick();
    u_if.cmd_done = 1'b0; u_if.rdata = 8'h00;
    chk("done_ignore_rdata", 32'(last_rdata), 32'h0B);
    chk("done_ignore_count", 32'(rd_count), 18);

    // restart from DONE, then reset during WAIT of instruction 2
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_rd_count", 32'(rd_count), 0);
    chk("restart_pc", 32'(pc), 0);
    chk("restart_busy", 32'(busy), 1);
    serve(0, 0, 1);
    serve(1, 0, 1);
    chk("restart_last_rdata", 32'(last_rdata), 3);
    wait_valid(ok);
    chk("pre_rst_pc", 32'(pc), 2);
    u_if.cmd_ready = 1'b1;
    tick();
    u_if.cmd_ready = 1'b0;
    chk("wait_valid_low", 32'(u_if.cmd_valid), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_pc", 32'(pc), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_valid", 32'(u_if.cmd_valid), 0);
    chk("midrst_last_rdata", 32'(last_rdata), 0);
    chk("midrst_rd_count", 32'(rd_count), 0);
    chk("midrst_cmd", 32'({u_if.cmd_write, u_if.cmd_burst, u_if.cmd_sel, u_if.cmd_addr, u_if.cmd_wdata}), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(ok);
    u_if.cmd_ready = 1'b1;
    tick();
    u_if.cmd_ready = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    repeat (7) tick();
    chk("to_still_wait", 32'(busy), 1);
    chk("to_no_error_yet", 32'(error), 0);
    tick();
    chk("to_done", 32'(done), 1);
    chk("to_error", 32'(error), 1);
    chk("to_pc", 32'(pc), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_error_clear", 32'(error), 0);
    chk("to_restart_busy", 32'(busy), 1);
`else
    repeat (20) tick();
    chk("nto_still_wait", 32'(busy), 1);
    chk("nto_error", 32'(error), 0);
    chk("nto_done", 32'(done), 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("final_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program sequencer between instructionmemory and the AHB master.
- Drives pc and registers the 23-bit instruction word.
- Decodes the word into a single command and hands it to the master with a valid/ready handshake.
- Waits for the master's completion, captures read data, then advances pc.
- Runs PROG_LEN instructions per start pulse, then reports done.

Parameters:
- PROG_LEN, 36: number of instructions executed per run, 1..1024.
- TIMEOUT, 64: cycles allowed in WAIT before abort (used only with SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE or DONE.
- pc  out  10  instruction memory address.
- instruction  in  23  word from memory, combinational on pc; fields [22]=write, [21:19]=burst, [18]=sel, [17:8]=addr, [7:0]=data.
- cmd_valid  out  1  command offered to master.
- cmd_ready  in  1  master accepts the command when cmd_valid && cmd_ready.
- cmd_write  out  1  1=write, 0=read.
- cmd_burst  out  3  burst code, passed through.
- cmd_sel  out  1  slave select.
- cmd_addr  out  10  slave address.
- cmd_wdata  out  8  write data.
- cmd_done  in  1  one-cycle pulse from master: transfer finished.
- rdata  in  8  read data; valid in the cycle cmd_done=1.
- last_rdata  out  8  most recent read result.
- rd_count  out  10  number of reads completed this run.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE state.
- error  out  1  timeout abort flag (always 0 without SEQ_TIMEOUT_EN).

Behaviour:
- Reset values:
  - State IDLE; pc=0; all cmd_* outputs 0.
  - last_rdata=0, rd_count=0, busy=0, done=0, error=0.
- FSM states: IDLE, FETCH, ISSUE, WAIT, NEXT, DONE.
- IDLE: on start=1, clear rd_count and error, set pc=0, go to FETCH. Otherwise hold.
- FETCH (1 cycle):
  - Register instruction fields into the cmd_* registers.
  - Go to ISSUE.
- ISSUE:
  - cmd_valid=1; cmd_* fields held stable.
  - Stay until cmd_ready=1; in that cycle the handshake completes and the next state is WAIT.
  - cmd_valid drops the cycle after acceptance.
  - The master's cmd_ready is never required to be high before cmd_valid.
- WAIT:
  - Stay until cmd_done=1.
  - On cmd_done with cmd_write=0: last_rdata<=rdata and rd_count<=rd_count+1.
  - Go to NEXT.
  - cmd_done seen in any other state is ignored.
- NEXT:
  - If pc==PROG_LEN-1, go to DONE; pc is held.
  - Else pc<=pc+1 and go to FETCH.
  - pc never wraps; with PROG_LEN=1024 the run ends at pc=1023.
- DONE:
  - done=1; last_rdata and rd_count are held for inspection.
  - On start=1, behave exactly as start in IDLE (new run from pc=0).
- start while busy is ignored.
- Latency per instruction with cmd_ready already high: FETCH(1) + ISSUE(1) + WAIT(n) + NEXT(1). A write that the master completes 2 cycles after acceptance therefore takes 5 cycles per instruction.
- rst=1 in any state, including mid-handshake: return to the reset values on the next edge. The master must treat the dropped cmd_valid as withdrawal.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without cmd_done: set error=1, go to DONE, and freeze pc at the faulting instruction.
  - error clears only on rst or a new start.
- When undefined:
  - No counter logic; WAIT waits indefinitely.
  - error is tied to 0.

Test Plan:
- Reset and idle: rst for 2 cycles, start=0 -> pc=0, busy=0, done=0, cmd_valid=0; state holds indefinitely.
- Single write: PROG_LEN=1, mem[0]=23'b1_000_0_0000000001_00000001, cmd_ready=1, cmd_done 2 cycles after accept -> one cmd_valid pulse with write=1, sel=0, addr=1, wdata=1; done=1 five cycles after start; rd_count=0.
- Read capture: PROG_LEN=2, mem[0]=write addr 2 data 2, mem[1]=read addr 2; master returns rdata=8'h02 -> last_rdata=8'h02, rd_count=1, final pc=1.
- Backpressure: hold cmd_ready=0 for 7 cycles in ISSUE -> cmd_valid stays 1 and cmd_addr/cmd_wdata stay constant; exactly one acceptance.
- Full program: PROG_LEN=36 with the 18 write/read pairs on slaves 0 and 1, master reads return the written data -> 36 handshakes; rd_count=18; last_rdata=8'h0B (slave 1, addr 9).
- Reset mid-WAIT, plus timeout: rst asserted during WAIT -> all outputs at reset values next cycle. With SEQ_TIMEOUT_EN, TIMEOUT=8 and cmd_done never asserted -> error=1 and done=1 after 8 WAIT cycles; pc unchanged.
